// File: rtl/sram_read_arbiter_pkg.sv
// Shared definitions for the SRAM read arbiter: requester ids, FSM states,
// default geometry and the per-word return tag.
package sram_read_arbiter_pkg;

  localparam int unsigned ADDR_W_DEF = 20;
  localparam int unsigned DATA_W_DEF = 64;
  localparam int unsigned RD_LAT_DEF = 3;
  localparam int unsigned NUM_REQ    = 2;
  localparam int unsigned LEN_W      = 2;

  typedef enum logic {
    REQ_FACE = 1'b0,
    REQ_VERT = 1'b1
  } req_id_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } state_e;

  typedef struct packed {
    req_id_e owner;
    logic    last;
  } rd_tag_t;

  localparam int unsigned TAG_W = $bits(rd_tag_t);

  function automatic logic [NUM_REQ-1:0] id_onehot(input req_id_e id);
    return (id == REQ_VERT) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/sram_read_arbiter_if.sv
// Request, SRAM and response signals of the read arbiter; slave = arbiter side.
interface sram_read_arbiter_if #(
  parameter int unsigned ADDR_W = 20,
  parameter int unsigned DATA_W = 64
);
  logic [1:0]        req_valid;
  logic [ADDR_W-1:0] req_addr0;
  logic [ADDR_W-1:0] req_addr1;
  logic [1:0]        req_len0;
  logic [1:0]        req_len1;
  logic [1:0]        req_ready;
  logic [ADDR_W-1:0] sram_addr;
  logic              sram_rd;
  logic [DATA_W-1:0] sram_rdata;
  logic [1:0]        rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_last;
  logic              busy;

  modport slave (
    input  req_valid, req_addr0, req_addr1, req_len0, req_len1, sram_rdata,
    output req_ready, sram_addr, sram_rd, rsp_valid, rsp_data, rsp_last, busy
  );

  modport master (
    output req_valid, req_addr0, req_addr1, req_len0, req_len1, sram_rdata,
    input  req_ready, sram_addr, sram_rd, rsp_valid, rsp_data, rsp_last, busy
  );
endinterface

// File: rtl/sram_read_arbiter_rd_tag_pipe.sv
// Valid/tag delay line that follows each SRAM read until its data returns.
module rd_tag_pipe #(
  parameter int unsigned DEPTH = 3,
  parameter int unsigned TAG_W = 2
) (
  input  logic             clk,
  input  logic             srst_n,
  input  logic             in_vld,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_vld,
  output logic [TAG_W-1:0] out_tag,
  output logic             any_vld
);

  logic [DEPTH-1:0]            vld_q, vld_d;
  logic [DEPTH-1:0][TAG_W-1:0] tag_q, tag_d;

  always_comb begin
    vld_d    = vld_q;
    tag_d    = tag_q;
    vld_d[0] = in_vld;
    tag_d[0] = in_tag;
    for (int unsigned i = 1; i < DEPTH; i++) begin
      vld_d[i] = vld_q[i-1];
      tag_d[i] = tag_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      vld_q <= '0;
      tag_q <= '0;
    end else begin
      vld_q <= vld_d;
      tag_q <= tag_d;
    end
  end

  assign out_vld = vld_q[DEPTH-1];
  assign out_tag = tag_q[DEPTH-1];
  assign any_vld = |vld_q;

endmodule

// File: rtl/sram_read_arbiter.sv
// Round-robin arbiter turning two burst read requesters into a single SRAM
// read stream, routing the fixed-latency return data back to its owner.
module sram_read_arbiter
  import sram_read_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned RD_LAT = RD_LAT_DEF
) (
  input  logic               clk,
  input  logic               srst_n,
  sram_read_arbiter_if.slave bus
);

  state_e              state_q, state_d;
  req_id_e             rr_pref_q, rr_pref_d;
  req_id_e             owner_q, owner_d;
  req_id_e             grant_id_c;
  logic                grant_en_c;
  logic [LEN_W-1:0]    beat_q, beat_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [ADDR_W-1:0]   sram_addr_q, sram_addr_d;
  logic [NUM_REQ-1:0]  req_ready_q, req_ready_d;
  logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic                sram_rd_q, sram_rd_d;
  logic                rsp_last_q, rsp_last_d;
  logic                busy_q, busy_d;
  rd_tag_t             tag_d, pipe_tag;
  logic [TAG_W-1:0]    tag_bits_d, pipe_tag_bits;
  logic                pipe_vld, pipe_any;

  // Sole requester wins; on a tie the one not granted last wins.
  always_comb begin
    grant_en_c = |bus.req_valid;
    case (bus.req_valid)
      2'b01:   grant_id_c = REQ_FACE;
      2'b10:   grant_id_c = REQ_VERT;
      default: grant_id_c = rr_pref_q;
    endcase
  end

  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (grant_en_c) state_d = ST_ISSUE;
      ST_ISSUE: if (beat_q == len_q) state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from next-state values so sram_rd tracks ISSUE exactly.
  always_comb begin
    beat_d      = beat_q;
    len_d       = len_q;
    base_d      = base_q;
    owner_d     = owner_q;
    rr_pref_d   = rr_pref_q;
    req_ready_d = '0;
    if (state_q == ST_IDLE) begin
      if (grant_en_c) begin
        beat_d      = '0;
        owner_d     = grant_id_c;
        rr_pref_d   = (grant_id_c == REQ_FACE) ? REQ_VERT : REQ_FACE;
        base_d      = (grant_id_c == REQ_VERT) ? bus.req_addr1 : bus.req_addr0;
        len_d       = (grant_id_c == REQ_VERT) ? bus.req_len1  : bus.req_len0;
        req_ready_d = id_onehot(grant_id_c);
      end
    end else begin
      beat_d = beat_q + LEN_W'(1);
    end
    sram_rd_d   = (state_d == ST_ISSUE);
    sram_addr_d = sram_rd_d ? (base_d + ADDR_W'(beat_d)) : sram_addr_q;
    tag_d.owner = owner_d;
    tag_d.last  = (beat_d == len_d);
    rsp_valid_d = pipe_vld ? id_onehot(pipe_tag.owner) : '0;
    rsp_last_d  = pipe_vld & pipe_tag.last;
    busy_d      = sram_rd_d | pipe_any;
  end

  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      beat_q      <= '0;
      len_q       <= '0;
      base_q      <= '0;
      owner_q     <= REQ_FACE;
      rr_pref_q   <= REQ_FACE;
      req_ready_q <= '0;
      sram_rd_q   <= 1'b0;
      sram_addr_q <= '0;
      rsp_valid_q <= '0;
      rsp_last_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      beat_q      <= beat_d;
      len_q       <= len_d;
      base_q      <= base_d;
      owner_q     <= owner_d;
      rr_pref_q   <= rr_pref_d;
      req_ready_q <= req_ready_d;
      sram_rd_q   <= sram_rd_d;
      sram_addr_q <= sram_addr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_last_q  <= rsp_last_d;
      busy_q      <= busy_d;
    end
  end

  // Tag enters alongside sram_rd_d so the final response register lands on the data cycle.
  assign tag_bits_d = tag_d;
  assign pipe_tag   = rd_tag_t'(pipe_tag_bits);

  rd_tag_pipe #(
    .DEPTH (RD_LAT),
    .TAG_W (TAG_W)
  ) u_tag_pipe (
    .clk     (clk),
    .srst_n  (srst_n),
    .in_vld  (sram_rd_d),
    .in_tag  (tag_bits_d),
    .out_vld (pipe_vld),
    .out_tag (pipe_tag_bits),
    .any_vld (pipe_any)
  );

  assign bus.req_ready = req_ready_q;
  assign bus.sram_rd   = sram_rd_q;
  assign bus.sram_addr = sram_addr_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_last  = rsp_last_q;
  assign bus.rsp_data  = DATA_W'(bus.sram_rdata);
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_sram_read_arbiter.sv
// Bench for sram_read_arbiter: queue-based transaction model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_sram_read_arbiter;
  import sram_read_arbiter_pkg::*;

  localparam int unsigned AW  = 20;
  localparam int unsigned DW  = 64;
  localparam int unsigned LAT = 3;

  logic clk    = 1'b0;
  logic srst_n = 1'b1;
  always #5 clk = ~clk;

  sram_read_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  sram_read_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT)) dut (
    .clk    (clk),
    .srst_n (srst_n),
    .bus    (bus)
  );

  typedef struct { logic [AW-1:0] addr; logic owner; logic last; } word_t;
  typedef struct { int due; logic [AW-1:0] addr; logic owner; logic last; } fly_t;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  word_t pend_q[$];
  fly_t  fly_q[$];
  logic       m_pref       = 1'b0;
  logic [1:0] m_ready_next = 2'b00;
  logic [1:0] hs           = 2'b00;

  logic [AW-1:0] log_addr[$];
  int            log_rd_cyc[$];
  logic [1:0]    log_rsp[$];
  logic          log_last[$];
  logic          log_rsp_rd[$];
  int            log_rsp_cyc[$];
  logic [1:0]    log_ready[$];

  function automatic logic [DW-1:0] mem(input logic [AW-1:0] a);
    return DW'((64'(a) * 64'h9E37_79B9_7F4A_7C15) ^ 64'h0123_4567_89AB_CDEF);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", nm, cyc, act, exp);
    end
  endtask

  // SRAM: returns mem(addr) LAT cycles after each observed read strobe.
  logic [LAT-1:0]         sh_rd = '0;
  logic [LAT-1:0][AW-1:0] sh_addr = '0;
  always @(posedge clk) begin
    for (int k = int'(LAT) - 1; k > 0; k--) begin
      sh_rd[k]   = sh_rd[k-1];
      sh_addr[k] = sh_addr[k-1];
    end
    sh_rd[0]   = bus.sram_rd;
    sh_addr[0] = bus.sram_addr;
    #1;
    bus.sram_rdata = sh_rd[LAT-1] ? mem(sh_addr[LAT-1]) : {$urandom, $urandom};
  end

  // Model + compare, sampled mid-cycle.
  always @(negedge clk) begin
    logic [1:0]    exp_ready, exp_rv, vld;
    logic          exp_rd, exp_last, exp_busy, g;
    logic [DW-1:0] exp_data;
    logic [AW-1:0] a;
    logic [1:0]    l;
    word_t         w;
    fly_t          f;
    cyc++;
    if (!srst_n) begin
      chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
      chk("rst_sram_rd",   64'(bus.sram_rd),   64'd0);
      chk("rst_sram_addr", 64'(bus.sram_addr), 64'd0);
      chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      chk("rst_rsp_last",  64'(bus.rsp_last),  64'd0);
      chk("rst_busy",      64'(bus.busy),      64'd0);
      pend_q.delete();
      fly_q.delete();
      m_pref       = 1'b0;
      m_ready_next = 2'b00;
      hs           = 2'b00;
    end else begin
      exp_ready    = m_ready_next;
      m_ready_next = 2'b00;
      exp_rd = 1'b0; exp_rv = 2'b00; exp_last = 1'b0; exp_data = '0;
      w = '{addr: '0, owner: 1'b0, last: 1'b0};
      if (pend_q.size() > 0) begin
        exp_rd = 1'b1;
        w = pend_q.pop_front();
        f.due = cyc + int'(LAT); f.addr = w.addr; f.owner = w.owner; f.last = w.last;
        fly_q.push_back(f);
      end
      exp_busy = (fly_q.size() > 0);
      if (fly_q.size() > 0 && fly_q[0].due == cyc) begin
        f = fly_q.pop_front();
        exp_rv   = f.owner ? 2'b10 : 2'b01;
        exp_last = f.last;
        exp_data = mem(f.addr);
      end
      chk("req_ready", 64'(bus.req_ready), 64'(exp_ready));
      chk("sram_rd",   64'(bus.sram_rd),   64'(exp_rd));
      if (exp_rd) chk("sram_addr", 64'(bus.sram_addr), 64'(w.addr));
      chk("rsp_valid", 64'(bus.rsp_valid), 64'(exp_rv));
      chk("rsp_last",  64'(bus.rsp_last),  64'(exp_last));
      if (exp_rv != 2'b00) chk("rsp_data", 64'(bus.rsp_data), 64'(exp_data));
      chk("busy", 64'(bus.busy), 64'(exp_busy));

      if (bus.sram_rd) begin log_addr.push_back(bus.sram_addr); log_rd_cyc.push_back(cyc); end
      if (bus.rsp_valid != 2'b00) begin
        log_rsp.push_back(bus.rsp_valid);
        log_last.push_back(bus.rsp_last);
        log_rsp_rd.push_back(bus.sram_rd);
        log_rsp_cyc.push_back(cyc);
      end
      if (bus.req_ready != 2'b00) log_ready.push_back(bus.req_ready);
      hs = bus.req_valid & bus.req_ready;

      // A grant may only be made in a cycle with nothing issuing.
      vld = bus.req_valid;
      if (!exp_rd && vld != 2'b00) begin
        g = (vld == 2'b11) ? m_pref : vld[1];
        a = g ? bus.req_addr1 : bus.req_addr0;
        l = g ? bus.req_len1  : bus.req_len0;
        for (int k = 0; k <= int'(l); k++) begin
          w.addr = a + AW'(k); w.owner = g; w.last = (k == int'(l));
          pend_q.push_back(w);
        end
        m_pref       = ~g;
        m_ready_next = g ? 2'b10 : 2'b01;
      end
    end
  end

  task automatic clear_logs();
    log_addr.delete(); log_rd_cyc.delete(); log_rsp.delete(); log_last.delete();
    log_rsp_rd.delete(); log_rsp_cyc.delete(); log_ready.delete();
  endtask

  // Advance one cycle; a requester drops valid (and scrambles its fields) after its handshake.
  task automatic tick();
    @(posedge clk);
    #1;
    for (int r = 0; r < 2; r++) begin
      if (bus.req_valid[r] && hs[r]) begin
        bus.req_valid[r] = 1'b0;
        if (r == 0) begin bus.req_addr0 = AW'($urandom); bus.req_len0 = 2'($urandom); end
        else        begin bus.req_addr1 = AW'($urandom); bus.req_len1 = 2'($urandom); end
      end
    end
  endtask

  task automatic raise(input int r, input logic [AW-1:0] a, input logic [1:0] l);
    if (r == 0) begin bus.req_addr0 = a; bus.req_len0 = l; end
    else        begin bus.req_addr1 = a; bus.req_len1 = l; end
    bus.req_valid[r] = 1'b1;
  endtask

  task automatic wait_quiet(input int maxc);
    int n = 0;
    while ((bus.req_valid != 2'b00 || bus.busy) && n < maxc) begin
      tick();
      n++;
    end
    chk("quiet_within_budget", 64'(n < maxc), 64'd1);
  endtask

  task automatic do_reset();
    srst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 srst_n = 1'b1;
  endtask

  logic [1:0] alt [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
  logic [AW-1:0] wrap_exp [4] = '{20'hFFFFE, 20'hFFFFF, 20'h00000, 20'h00001};

  initial begin
    int cnt;
    bus.req_valid = 2'b00;
    bus.req_addr0 = '0; bus.req_addr1 = '0;
    bus.req_len0  = '0; bus.req_len1  = '0;
    bus.sram_rdata = '0;
    #2 srst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 srst_n = 1'b1;

    // Idle.
    clear_logs();
    repeat (20) tick();
    chk("idle_no_issue", 64'(log_addr.size()), 64'd0);
    chk("idle_no_grant", 64'(log_ready.size()), 64'd0);

    // Single burst.
    clear_logs();
    raise(0, 20'h00010, 2'd2);
    wait_quiet(40);
    chk("single_grants", 64'(log_ready.size()), 64'd1);
    chk("single_ready0", 64'(log_ready[0]), 64'h1);
    chk("single_nwords", 64'(log_addr.size()), 64'd3);
    for (int i = 0; i < 3; i++) begin
      chk("single_addr", 64'(log_addr[i]), 64'(20'h00010 + i));
      chk("single_rsp",  64'(log_rsp[i]),  64'h1);
      chk("single_last", 64'(log_last[i]), 64'(i == 2));
    end
    chk("single_consecutive", 64'(log_rd_cyc[2] - log_rd_cyc[0]), 64'd2);
    chk("single_latency", 64'(log_rsp_cyc[0] - log_rd_cyc[0]), 64'(LAT));

    // Contention after reset: requester 0 wins the first tie.
    do_reset();
    clear_logs();
    raise(0, 20'h00100, 2'd0);
    raise(1, 20'h00200, 2'd0);
    for (int n = 0; n < 40 && (bus.req_valid != 2'b00 || bus.busy); n++) begin
      tick();
      if (log_ready.size() < 3) begin
        if (!bus.req_valid[0]) raise(0, 20'h00100 + AW'(log_ready.size()), 2'd0);
        if (!bus.req_valid[1]) raise(1, 20'h00200 + AW'(log_ready.size()), 2'd0);
      end
    end
    wait_quiet(40);
    chk("cont_grants", 64'(log_ready.size()), 64'd4);
    chk("cont_rsps", 64'(log_rsp.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      chk("cont_grant_order", 64'(log_ready[i]), 64'(alt[i]));
      chk("cont_rsp_route",   64'(log_rsp[i]),   64'(alt[i]));
    end

    // Address wrap.
    clear_logs();
    raise(1, 20'hFFFFE, 2'd3);
    wait_quiet(40);
    chk("wrap_nwords", 64'(log_addr.size()), 64'd4);
    for (int i = 0; i < 4; i++) chk("wrap_addr", 64'(log_addr[i]), 64'(wrap_exp[i]));

    // Overlap of returns with the next burst's issue.
    clear_logs();
    raise(0, 20'h00400, 2'd0);
    for (int n = 0; n < 20; n++) begin
      tick();
      if (!bus.req_valid[0]) break;
    end
    raise(1, 20'h00500, 2'd3);
    wait_quiet(40);
    chk("ovl_nrsp", 64'(log_rsp.size()), 64'd5);
    chk("ovl_first_owner", 64'(log_rsp[0]), 64'h1);
    chk("ovl_first_during_issue", 64'(log_rsp_rd[0]), 64'd1);
    for (int i = 1; i < 5; i++) chk("ovl_vert_route", 64'(log_rsp[i]), 64'h2);
    chk("ovl_last_face", 64'(log_last[0]), 64'd1);
    chk("ovl_last_vert", 64'(log_last[4]), 64'd1);

    // Reset mid-flight, one cycle after the second issued word.
    clear_logs();
    raise(0, 20'h00800, 2'd3);
    cnt = 0;
    for (int n = 0; n < 20 && cnt < 2; n++) begin
      tick();
      if (bus.sram_rd) cnt++;
    end
    tick();
    chk("mid_busy_before", 64'(bus.busy), 64'd1);
    srst_n = 1'b0;
    #1;
    chk("mid_req_ready", 64'(bus.req_ready), 64'd0);
    chk("mid_sram_rd",   64'(bus.sram_rd),   64'd0);
    chk("mid_sram_addr", 64'(bus.sram_addr), 64'd0);
    chk("mid_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("mid_rsp_last",  64'(bus.rsp_last),  64'd0);
    chk("mid_busy",      64'(bus.busy),      64'd0);
    repeat (2) @(posedge clk);
    #1 srst_n = 1'b1;
    clear_logs();
    repeat (8) tick();
    chk("mid_no_stale_rsp", 64'(log_rsp.size()), 64'd0);
    chk("mid_no_issue", 64'(log_addr.size()), 64'd0);

    // Random traffic.
    clear_logs();
    for (int n = 0; n < 600; n++) begin
      tick();
      for (int r = 0; r < 2; r++) begin
        if (!bus.req_valid[r] && $urandom_range(0, 2) == 0)
          raise(r, ($urandom_range(0, 3) == 0) ? 20'hFFFFD : AW'($urandom), 2'($urandom));
      end
    end
    wait_quiet(100);
    chk("rand_activity", 64'(log_ready.size() > 20), 64'd1);
    chk("rand_rsp_count", 64'(log_rsp.size()), 64'(log_addr.size()));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_read_arbiter.md
SRAM_READ_ARBITER -- requirements
Module: sram_read_arbiter

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
- ADDR_W, 20, SRAM word address width.
- DATA_W, 64, SRAM read data width.
- RD_LAT, 3, fixed SRAM read latency in cycles; legal range 1..7.

REQ-002 Ports (name, direction, width, meaning) SHALL be:
- clk, in, 1, single clock, rising edge.
- srst_n, in, 1, asynchronous active-low reset.
- req_valid, in, 2, per-requester read request; bit0 = face fetch (controller), bit1 = vertex fetch (shader).
- req_addr0, in, ADDR_W, requester 0 start address.
- req_addr1, in, ADDR_W, requester 1 start address.
- req_len0, in, 2, requester 0 burst length minus 1 (1..4 words).
- req_len1, in, 2, requester 1 burst length minus 1 (1..4 words).
- req_ready, out, 2, per-requester acceptance pulse; the burst is accepted in a cycle where valid and ready are both 1.
- sram_addr, out, ADDR_W, SRAM read address, registered.
- sram_rd, out, 1, SRAM read strobe, registered.
- sram_rdata, in, DATA_W, SRAM data, valid RD_LAT cycles after its sram_rd.
- rsp_valid, out, 2, per-requester return-data strobe, one cycle per word.
- rsp_data, out, DATA_W, return data, broadcast to both requesters.
- rsp_last, out, 1, marks the final word of a burst.
- busy, out, 1, high while a burst is issuing or any read is in flight.

Function
REQ-003 The state machine SHALL have two states: IDLE (no burst issuing) and ISSUE (one word issued per cycle).
REQ-004 In IDLE with any req_valid set, the arbiter SHALL grant one requester, pulse its req_ready for one cycle, latch its address and length, and enter ISSUE on the next edge.
REQ-005 Arbitration SHALL be round-robin:
- A sole requester is granted.
- On a simultaneous request, the requester not granted last is granted.
- After reset, requester 0 wins the first tie.
REQ-006 In ISSUE the block SHALL drive sram_rd=1 and sram_addr = latched base + beat count for len+1 consecutive cycles, then return to IDLE.
REQ-007 sram_addr SHALL wrap modulo 2^ADDR_W; a burst crossing the top address continues at 0.
REQ-008 A new grant SHALL NOT be made while in ISSUE.
- Back-to-back bursts have one IDLE cycle between them.
- Requests pending during ISSUE are held by the requester (valid stays high) and arbitrated in that IDLE cycle.
REQ-009 Each issued word SHALL carry a tag {owner id, last flag} through an RD_LAT-deep valid/tag shift pipeline aligned to sram_rd.
REQ-010 When a tag exits the pipeline, the block SHALL assert rsp_valid[owner] for that cycle.
- rsp_data = sram_rdata, passed through with no extra register.
- rsp_last = last flag.
REQ-011 Response order SHALL equal issue order; returns for a new burst may overlap issue of the next burst.
REQ-012 req_ready SHALL never be asserted for a requester whose req_valid is 0; at most one req_ready bit is high per cycle.
REQ-013 busy SHALL be 1 when the state is ISSUE or any pipeline valid bit is set, else 0.
REQ-014 Changes to req_addr/req_len after acceptance SHALL have no effect on the accepted burst.

Reset
REQ-015 On srst_n low, the block SHALL asynchronously clear the following to 0:
- state (to IDLE), beat counter, round-robin pointer (to favour requester 0).
- all pipeline valid bits, sram_rd, sram_addr, req_ready, rsp_valid, rsp_last, busy.
REQ-016 Reset mid-burst or with reads in flight SHALL discard them; no rsp_valid is produced for pre-reset reads after release.
REQ-017 After srst_n deasserts, the first grant SHALL occur no earlier than the first rising edge with srst_n high.

Structure
REQ-018 The requester id encodings (FACE=0, VERT=1), the state encodings, and the RD_LAT default SHALL live in the shared render package.
REQ-019 The tag/valid delay line SHALL be a sub-module named rd_tag_pipe, parameterised by depth and tag width.

Verification
REQ-020 Single burst: req_valid=01, addr0=0x00010, len0=2 -> req_ready=01 for 1 cycle; sram_addr 0x10,0x11,0x12 on 3 consecutive cycles; rsp_valid=01 for 3 cycles starting RD_LAT cycles after the first issue; rsp_last on the third.
REQ-021 Contention: req_valid=11 held, both len=0 -> grants alternate 0,1,0,1; each response is routed to the matching rsp_valid bit in order.
REQ-022 Wrap: addr1=0xFFFFE, len1=3 -> sram_addr 0xFFFFE,0xFFFFF,0x00000,0x00001.
REQ-023 Overlap: a len0=0 burst followed immediately by a len1=3 burst -> the response for requester 0 arrives while requester 1 is still issuing; no lost or misrouted words.
REQ-024 Reset mid-flight: assert srst_n=0 one cycle after the second issued word of a 4-word burst -> all outputs are 0 immediately; no rsp_valid in the 8 cycles after release.
REQ-025 Idle: req_valid=00 for 20 cycles -> sram_rd=0, busy=0, req_ready=00 throughout.
